// File: rtl/alu_pkg.sv
// Shared constants for the sequenced ALU: opcodes, flag bit positions,
// button roles and FSM state encodings.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

    localparam int FLAG_Z   = 0;
    localparam int FLAG_C   = 1;
    localparam int FLAG_V   = 2;
    localparam int FLAG_INV = 3;

    localparam int BTN_A  = 0;
    localparam int BTN_B  = 1;
    localparam int BTN_OP = 2;

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        EXEC    = 2'd3
    } state_e;

endpackage

// File: rtl/alu_sequenced_core_if.sv
// Board-side bundle of the sequenced ALU: switches and buttons in,
// registered result, flags, strobes and FSM state out.
interface alu_sequenced_core_if #(
    parameter int BITS_DATA = 8,
    parameter int BUTTONS   = 3
);
    // Handshake: o_valid and o_seq_err are single-cycle strobes with no ready
    // or backpressure; o_result/o_flags are valid from the o_valid cycle and
    // hold until the next o_valid.
    logic [BITS_DATA-1:0] i_switches;
    logic [BUTTONS-1:0]   i_buttons;
    logic [BITS_DATA-1:0] o_result;
    logic [3:0]           o_flags;
    logic                 o_valid;
    logic                 o_seq_err;
    logic [1:0]           o_state;

    modport master (
        output i_switches, i_buttons,
        input  o_result, o_flags, o_valid, o_seq_err, o_state
    );

    modport slave (
        input  i_switches, i_buttons,
        output o_result, o_flags, o_valid, o_seq_err, o_state
    );

endinterface

// File: rtl/button_debouncer.sv
// One raw button: two-flop synchroniser, stability counter and rising-edge
// detector producing a single-cycle press event.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_press
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             stable_prev_q, stable_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The debounced level flips only on the DEBOUNCE_CYCLES-th consecutive
    // synchronised sample that disagrees with it; any agreeing sample restarts.
    always_comb begin
        sync1_d       = i_raw;
        sync2_d       = sync1_q;
        stable_d      = stable_q;
        stable_prev_d = stable_q;
        cnt_d         = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            cnt_q         <= cnt_d;
        end
    end

    assign o_press = stable_q & ~stable_prev_q;

endmodule

// File: rtl/alu_sequenced_core.sv
// Button-driven ALU: debounced presses load A, B and OP in order, then one
// EXEC cycle registers the result and flags and pulses o_valid.
module alu_sequenced_core
    import alu_pkg::*;
#(
    parameter int BITS_DATA       = 8,
    parameter int BITS_OP         = 6,
    parameter int BUTTONS         = 3,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 i_reset,
    alu_sequenced_core_if.slave  bus
);
    localparam int W = BITS_DATA;

    localparam logic [BITS_OP-1:0] C_ADD = BITS_OP'(OP_ADD);
    localparam logic [BITS_OP-1:0] C_SUB = BITS_OP'(OP_SUB);
    localparam logic [BITS_OP-1:0] C_AND = BITS_OP'(OP_AND);
    localparam logic [BITS_OP-1:0] C_OR  = BITS_OP'(OP_OR);
    localparam logic [BITS_OP-1:0] C_XOR = BITS_OP'(OP_XOR);
    localparam logic [BITS_OP-1:0] C_NOR = BITS_OP'(OP_NOR);
    localparam logic [BITS_OP-1:0] C_SRL = BITS_OP'(OP_SRL);
    localparam logic [BITS_OP-1:0] C_SRA = BITS_OP'(OP_SRA);
    localparam logic [W-1:0]       SHIFT_LIMIT = W'(BITS_DATA);

    logic [BUTTONS-1:0] press;
    logic               any_press;
    logic               multi_press;

    state_e             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [BITS_OP-1:0] op_q, op_d;
    logic [W-1:0]       result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic               valid_q, valid_d;
    logic               seq_err_q, seq_err_d;

    logic [W:0]         sum;
    logic [W-1:0]       alu_res;
    logic [3:0]         alu_flags;

    for (genvar g = 0; g < BUTTONS; g++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk    (clk),
            .i_reset(i_reset),
            .i_raw  (bus.i_buttons[g]),
            .o_press(press[g])
        );
    end

    assign any_press   = |press;
    assign multi_press = |(press & (press - BUTTONS'(1)));

    always_comb begin
        sum       = '0;
        alu_res   = '0;
        alu_flags = '0;
        case (op_q)
            C_ADD: begin
                sum                 = {1'b0, a_q} + {1'b0, b_q};
                alu_res             = sum[W-1:0];
                alu_flags[FLAG_C]   = sum[W];
                alu_flags[FLAG_V]   = (a_q[W-1] == b_q[W-1]) && (alu_res[W-1] != a_q[W-1]);
            end
            C_SUB: begin
                alu_res             = a_q - b_q;
                alu_flags[FLAG_C]   = (a_q < b_q);
                alu_flags[FLAG_V]   = (a_q[W-1] != b_q[W-1]) && (alu_res[W-1] != a_q[W-1]);
            end
            C_AND: alu_res = a_q & b_q;
            C_OR:  alu_res = a_q | b_q;
            C_XOR: alu_res = a_q ^ b_q;
            C_NOR: alu_res = ~(a_q | b_q);
            // Oversized shift amounts saturate explicitly rather than relying
            // on the operator's out-of-range behaviour.
            C_SRL: alu_res = (b_q >= SHIFT_LIMIT) ? '0 : (a_q >> b_q);
            C_SRA: alu_res = (b_q >= SHIFT_LIMIT) ? {W{a_q[W-1]}} : W'($signed(a_q) >>> b_q);
            default: alu_flags[FLAG_INV] = 1'b1;
        endcase
        alu_flags[FLAG_Z] = (alu_res == '0);
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        result_d  = result_q;
        flags_d   = flags_q;
        valid_d   = 1'b0;
        seq_err_d = 1'b0;
        unique case (state_q)
            WAIT_A: begin
                if (any_press) begin
                    if (!multi_press && press[BTN_A]) begin
                        a_d     = bus.i_switches;
                        state_d = WAIT_B;
                    end else begin
                        seq_err_d = 1'b1;
                    end
                end
            end
            WAIT_B: begin
                if (any_press) begin
                    if (!multi_press && press[BTN_B]) begin
                        b_d     = bus.i_switches;
                        state_d = WAIT_OP;
                    end else begin
                        seq_err_d = 1'b1;
                    end
                end
            end
            WAIT_OP: begin
                if (any_press) begin
                    if (!multi_press && press[BTN_OP]) begin
                        op_d    = bus.i_switches[BITS_OP-1:0];
                        state_d = EXEC;
                    end else begin
                        seq_err_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                // EXEC always completes in one cycle; a press here is only flagged.
                result_d  = alu_res;
                flags_d   = alu_flags;
                valid_d   = 1'b1;
                state_d   = WAIT_A;
                seq_err_d = any_press;
            end
            default: state_d = WAIT_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q   <= WAIT_A;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            valid_q   <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            valid_q   <= valid_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign bus.o_result  = result_q;
    assign bus.o_flags   = flags_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_seq_err = seq_err_q;
    assign bus.o_state   = state_q;

endmodule
